// File: rtl/mic_pkg.sv
// Shared types for the mic front-end: complex FFT bin, bin power, and the
// frame size / peripheral count defaults also used by the direction calculator.
package mic_pkg;

  typedef struct packed {
    logic signed [15:0] re;
    logic signed [15:0] im;
  } cplx_t;

  typedef logic [32:0] pow_t;

  localparam int unsigned FFT_SIZE_DEF   = 1024;
  localparam int unsigned NUM_PERIPH_DEF = 3;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

endpackage

// File: rtl/complex_pow_sq.sv
// One registered stage computing re^2 + im^2 of a complex bin as an unsigned
// 33-bit power; operands are sign-extended first so (-32768)^2 stays exact.
module complex_pow_sq
  import mic_pkg::*;
(
  input  logic  clk_in,
  input  logic  rst_in_n,
  input  cplx_t i_val,
  output pow_t  o_pow
);

  logic signed [31:0] w_re;
  logic signed [31:0] w_im;
  logic signed [31:0] w_re_sq;
  logic signed [31:0] w_im_sq;
  pow_t               r_pow;

  assign w_re    = {{16{i_val.re[15]}}, i_val.re};
  assign w_im    = {{16{i_val.im[15]}}, i_val.im};
  assign w_re_sq = w_re * w_re;
  assign w_im_sq = w_im * w_im;

  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) r_pow <= '0;
    else           r_pow <= {1'b0, w_re_sq} + {1'b0, w_im_sq};
  end

  assign o_pow = r_pow;

endmodule

// File: rtl/fft_peak_bin_capture.sv
// Finds the peak-power central-mic bin of each FFT frame and presents all mics'
// values at that bin as one held snapshot.  Slot: EMPTY = none held | FULL = presented.
module fft_peak_bin_capture
  import mic_pkg::*;
#(
  parameter  int unsigned NUM_PERIPH = NUM_PERIPH_DEF,
  parameter  int unsigned FFT_SIZE   = FFT_SIZE_DEF,
  parameter  int unsigned BIN_LO     = 1,
  parameter  int unsigned BIN_HI     = FFT_SIZE / 2 - 1,
  parameter  pow_t        MAG_MIN    = '0,
  localparam int unsigned BW         = $clog2(FFT_SIZE)
) (
  input  logic                       clk_in,
  input  logic                       rst_in_n,
  input  logic [31:0]                central_tdata,
  input  logic [NUM_PERIPH-1:0][31:0] periph_tdata,
  input  logic                       in_tvalid,
  input  logic                       in_tlast,
  output logic                       in_tready,
  output logic [31:0]                central_mic,
  output logic [NUM_PERIPH-1:0][31:0] peripheral_mics,
  output logic [BW-1:0]              peak_bin,
  output pow_t                       peak_pow,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       overflow,
  output logic                       frame_error
);

  localparam logic [BW-1:0] LAST_BIN = BW'(FFT_SIZE - 1);
  localparam logic [BW-1:0] LO_BIN   = BW'(BIN_LO);
  localparam logic [BW-1:0] HI_BIN   = BW'(BIN_HI);

  logic [BW-1:0] r_bin_cnt;
  logic          w_at_last;

  assign in_tready = 1'b1;
  assign w_at_last = (r_bin_cnt == LAST_BIN);

  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n)      r_bin_cnt <= '0;
    else if (in_tvalid) r_bin_cnt <= (in_tlast || w_at_last) ? '0 : r_bin_cnt + 1'b1;
  end

  // Stage 1: registered beat alongside the registered power
  logic                        r_s1_valid, r_s1_end, r_s1_err;
  logic [BW-1:0]               r_s1_bin;
  logic [31:0]                 r_s1_central;
  logic [NUM_PERIPH-1:0][31:0] r_s1_periph;
  pow_t                        w_s1_pow;

  complex_pow_sq u_pow (
    .clk_in   (clk_in),
    .rst_in_n (rst_in_n),
    .i_val    (cplx_t'(central_tdata)),
    .o_pow    (w_s1_pow)
  );

  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      r_s1_valid   <= 1'b0;
      r_s1_end     <= 1'b0;
      r_s1_err     <= 1'b0;
      r_s1_bin     <= '0;
      r_s1_central <= '0;
      r_s1_periph  <= '0;
    end else begin
      r_s1_valid   <= in_tvalid;
      r_s1_end     <= in_tvalid && in_tlast && w_at_last;
      r_s1_err     <= in_tvalid && (in_tlast ^ w_at_last);
      r_s1_bin     <= r_bin_cnt;
      r_s1_central <= central_tdata;
      r_s1_periph  <= periph_tdata;
    end
  end

  // Stage 2: best candidate; a frame boundary one stage ahead zeroes the baseline
  logic                        r_s2_end, r_s2_err;
  pow_t                        r_best_pow;
  logic [BW-1:0]               r_best_bin;
  logic [31:0]                 r_best_central;
  logic [NUM_PERIPH-1:0][31:0] r_best_periph;
  pow_t                        w_base_pow;
  logic                        w_take;
  logic                        w_commit;

  assign w_base_pow = (r_s2_end || r_s2_err) ? '0 : r_best_pow;
  assign w_take     = r_s1_valid && !r_s1_err && (r_s1_bin >= LO_BIN) &&
                      (r_s1_bin <= HI_BIN) && (w_s1_pow > w_base_pow);
  assign w_commit   = r_s2_end && (r_best_pow > MAG_MIN);

  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      r_s2_end       <= 1'b0;
      r_s2_err       <= 1'b0;
      r_best_pow     <= '0;
      r_best_bin     <= '0;
      r_best_central <= '0;
      r_best_periph  <= '0;
    end else begin
      r_s2_end <= r_s1_end;
      r_s2_err <= r_s1_err;
      if (w_take) begin
        r_best_pow     <= w_s1_pow;
        r_best_bin     <= r_s1_bin;
        r_best_central <= r_s1_central;
        r_best_periph  <= r_s1_periph;
      end else if (r_s2_end || r_s2_err) begin
        r_best_pow <= '0;
      end
    end
  end

  slot_state_t r_state, w_state_nxt;
  logic        w_accept, w_load, w_ovf;

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_ovf       = 1'b0;
    w_accept    = (r_state == SLOT_FULL) && out_ready;
    case (r_state)
      SLOT_EMPTY: begin
        if (w_commit) begin
          w_state_nxt = SLOT_FULL;
          w_load      = 1'b1;
        end
      end
      SLOT_FULL: begin
        if (w_commit) begin
          if (w_accept) w_load = 1'b1;
          else          w_ovf  = 1'b1;
        end else if (w_accept) begin
          w_state_nxt = SLOT_EMPTY;
        end
      end
      default: w_state_nxt = SLOT_EMPTY;
    endcase
  end

  logic [31:0]                 r_out_central;
  logic [NUM_PERIPH-1:0][31:0] r_out_periph;
  logic [BW-1:0]               r_out_bin;
  pow_t                        r_out_pow;
  logic                        r_overflow, r_frame_error;

  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      r_state       <= SLOT_EMPTY;
      r_out_central <= '0;
      r_out_periph  <= '0;
      r_out_bin     <= '0;
      r_out_pow     <= '0;
      r_overflow    <= 1'b0;
      r_frame_error <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_overflow    <= w_ovf;
      r_frame_error <= r_s2_err;
      if (w_load) begin
        r_out_central <= r_best_central;
        r_out_periph  <= r_best_periph;
        r_out_bin     <= r_best_bin;
        r_out_pow     <= r_best_pow;
      end
    end
  end

  assign out_valid       = (r_state == SLOT_FULL);
  assign central_mic     = r_out_central;
  assign peripheral_mics = r_out_periph;
  assign peak_bin        = r_out_bin;
  assign peak_pow        = r_out_pow;
  assign overflow        = r_overflow;
  assign frame_error     = r_frame_error;

endmodule

// File: tb/tb_fft_peak_bin_capture.sv
// Bench for fft_peak_bin_capture: frame-level reference model checked every
// cycle, plus directed frames with hand-computed expectations.
module tb_fft_peak_bin_capture;
  import mic_pkg::*;

  localparam int NP = 3;
  localparam int N  = 1024;
  localparam int LO = 1;
  localparam int HI = 511;

  logic                clk_in = 1'b0;
  logic                rst_in_n = 1'b0;
  logic [31:0]         central_tdata = '0;
  logic [NP-1:0][31:0] periph_tdata = '0;
  logic                in_tvalid = 1'b0;
  logic                in_tlast = 1'b0;
  logic                out_ready = 1'b0;
  logic                in_tready;
  logic [31:0]         central_mic;
  logic [NP-1:0][31:0] peripheral_mics;
  logic [9:0]          peak_bin;
  pow_t                peak_pow;
  logic                out_valid, overflow, frame_error;

  always #5 clk_in = ~clk_in;

  fft_peak_bin_capture dut (
    .clk_in          (clk_in),
    .rst_in_n        (rst_in_n),
    .central_tdata   (central_tdata),
    .periph_tdata    (periph_tdata),
    .in_tvalid       (in_tvalid),
    .in_tlast        (in_tlast),
    .in_tready       (in_tready),
    .central_mic     (central_mic),
    .peripheral_mics (peripheral_mics),
    .peak_bin        (peak_bin),
    .peak_pow        (peak_pow),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .overflow        (overflow),
    .frame_error     (frame_error)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int                  at;
    bit                  err;
    logic [31:0]         cen;
    logic [NP-1:0][31:0] per;
    int                  bin;
    longint              pow;
  } ev_t;

  ev_t                 evq[$];
  longint              fpow[N];
  logic [31:0]         fcen[N];
  logic [NP-1:0][31:0] fper[N];
  bit                  seen[N];
  int                  mbin, edge_n;
  bit                  exp_valid, exp_ovf, exp_ferr;
  logic [31:0]         exp_cen;
  logic [NP-1:0][31:0] exp_per;
  int                  exp_bin;
  longint              exp_pow;

  function automatic longint pw(input logic [31:0] d);
    longint re, im;
    re = longint'($signed(d[31:16]));
    im = longint'($signed(d[15:0]));
    return re * re + im * im;
  endfunction

  task automatic clear_seen();
    foreach (seen[b]) seen[b] = 1'b0;
  endtask

  always @(posedge clk_in or negedge rst_in_n) begin
    bit     accept, commit, at_end;
    ev_t    ev;
    int     b;
    longint best;
    if (!rst_in_n) begin
      evq.delete();
      clear_seen();
      mbin = 0; edge_n = 0;
      exp_valid = 0; exp_ovf = 0; exp_ferr = 0;
      exp_cen = '0; exp_per = '0; exp_bin = 0; exp_pow = 0;
    end else begin
      edge_n++;
      accept = exp_valid && out_ready;
      exp_ovf = 0; exp_ferr = 0; commit = 0;
      if (evq.size() > 0 && evq[0].at == edge_n) begin
        ev = evq.pop_front();
        if (ev.err) exp_ferr = 1;
        else        commit = 1;
      end
      if (commit && (!exp_valid || accept)) begin
        exp_valid = 1;
        exp_cen = ev.cen; exp_per = ev.per; exp_bin = ev.bin; exp_pow = ev.pow;
      end else if (commit) begin
        exp_ovf = 1;
      end else if (accept) begin
        exp_valid = 0;
      end
      if (in_tvalid) begin
        b = mbin;
        at_end = (b == N - 1);
        fpow[b] = pw(central_tdata); fcen[b] = central_tdata; fper[b] = periph_tdata; seen[b] = 1;
        if (in_tlast && at_end) begin
          best = 0;
          ev.bin = 0;
          for (int k = LO; k <= HI; k++)
            if (seen[k] && fpow[k] > best) begin
              best = fpow[k]; ev.bin = k;
            end
          if (best > 0) begin
            ev.at = edge_n + 2; ev.err = 0; ev.pow = best;
            ev.cen = fcen[ev.bin]; ev.per = fper[ev.bin];
            evq.push_back(ev);
          end
          clear_seen();
        end else if (in_tlast || at_end) begin
          ev.at = edge_n + 2; ev.err = 1; ev.bin = 0; ev.pow = 0;
          ev.cen = '0; ev.per = '0;
          evq.push_back(ev);
          clear_seen();
        end
        mbin = (in_tlast || at_end) ? 0 : b + 1;
      end
    end
  end

  always @(negedge clk_in) begin
    if (rst_in_n) begin
      chk("tready", 64'(in_tready), 64'(1'b1));
      chk("out_valid", 64'(out_valid), 64'(exp_valid));
      chk("overflow", 64'(overflow), 64'(exp_ovf));
      chk("frame_error", 64'(frame_error), 64'(exp_ferr));
      if (exp_valid) begin
        chk("central_mic", 64'(central_mic), 64'(exp_cen));
        chk("peak_bin", 64'(peak_bin), 64'(exp_bin));
        chk("peak_pow", 64'(peak_pow), 64'(exp_pow));
        for (int i = 0; i < NP; i++)
          chk($sformatf("periph%0d", i), 64'(peripheral_mics[i]), 64'(exp_per[i]));
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [31:0]         fr_cen[N];
  logic [NP-1:0][31:0] fr_per[N];
  bit                  rdy_rand = 0;
  int                  gap_pct = 0;

  task automatic tick();
    @(posedge clk_in);
    #1;
    if (rdy_rand) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic zero_frame();
    foreach (fr_cen[i]) begin
      fr_cen[i] = '0;
      fr_per[i] = '0;
    end
  endtask

  task automatic send_range(input int s, input int e, input int tl);
    for (int i = s; i <= e; i++) begin
      if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
        in_tvalid = 0;
        tick();
      end
      central_tdata = fr_cen[i];
      periph_tdata  = fr_per[i];
      in_tlast      = (i == tl);
      in_tvalid     = 1;
      tick();
      in_tvalid = 0;
      in_tlast  = 0;
    end
  endtask

  task automatic send_frame();
    send_range(0, N - 1, N - 1);
  endtask

  task automatic at_commit();
    tick();
    tick();
  endtask

  task automatic drain();
    out_ready = 1;
    tick();
    chk("drain_valid", 64'(out_valid), 64'(1'b0));
    out_ready = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1);
  end

  initial begin
    logic [15:0] vre, vim;
    int          len;
    repeat (3) tick();
    chk("rst_valid", 64'(out_valid), 64'(1'b0));
    chk("rst_pow", 64'(peak_pow), 64'(0));
    chk("rst_tready", 64'(in_tready), 64'(1'b1));
    rst_in_n = 1;
    tick();

    // bin 37 peak, latency and captured values
    zero_frame();
    fr_cen[37] = 32'h0100_0000;
    fr_per[37] = {3{32'h0000_0200}};
    send_frame();
    tick();
    chk("t2_early_valid", 64'(out_valid), 64'(1'b0));
    tick();
    chk("t2_valid", 64'(out_valid), 64'(1'b1));
    chk("t2_bin", 64'(peak_bin), 64'(37));
    chk("t2_pow", 64'(peak_pow), 64'(65536));
    chk("t2_central", 64'(central_mic), 64'(32'h0100_0000));
    for (int i = 0; i < NP; i++) chk("t2_periph", 64'(peripheral_mics[i]), 64'(32'h0000_0200));
    chk("t2_model_bin", 64'(exp_bin), 64'(37));

    // async reset mid-frame while a snapshot is held
    zero_frame();
    fr_cen[200] = 32'h0040_0000;
    send_range(0, 499, N - 1);
    rst_in_n = 0;
    #1;
    chk("t1_valid", 64'(out_valid), 64'(1'b0));
    chk("t1_bin", 64'(peak_bin), 64'(0));
    chk("t1_pow", 64'(peak_pow), 64'(0));
    chk("t1_central", 64'(central_mic), 64'(0));
    chk("t1_periph", 64'(peripheral_mics), 64'(0));
    chk("t1_ovf", 64'(overflow), 64'(1'b0));
    chk("t1_ferr", 64'(frame_error), 64'(1'b0));
    chk("t1_tready", 64'(in_tready), 64'(1'b1));
    tick();
    tick();
    rst_in_n = 1;
    send_range(500, N - 1, N - 1);
    tick();
    chk("t1_ferr_early", 64'(frame_error), 64'(1'b0));
    tick();
    chk("t1_ferr_pulse", 64'(frame_error), 64'(1'b1));
    chk("t1_no_valid", 64'(out_valid), 64'(1'b0));

    // ties resolve to the lowest bin; out-of-range bins ignored
    zero_frame();
    fr_cen[10]  = 32'h0030_0000;
    fr_cen[20]  = 32'h0000_FFD0;
    fr_cen[0]   = 32'h7000_0000;
    fr_cen[600] = 32'h7000_7000;
    send_frame();
    at_commit();
    chk("t3_bin", 64'(peak_bin), 64'(10));
    chk("t3_pow", 64'(peak_pow), 64'(2304));
    drain();

    // range edges: bin 511 searched, bins 0 and 512 not
    zero_frame();
    fr_cen[1]   = 32'h0000_0001;
    fr_cen[511] = 32'h0002_0000;
    fr_cen[512] = 32'h0100_0000;
    fr_cen[0]   = 32'h0100_0000;
    send_frame();
    at_commit();
    chk("t3b_bin", 64'(peak_bin), 64'(511));
    chk("t3b_pow", 64'(peak_pow), 64'(4));
    drain();

    // most negative operands
    zero_frame();
    fr_cen[5] = 32'h8000_8000;
    send_frame();
    at_commit();
    chk("t4_bin", 64'(peak_bin), 64'(5));
    chk("t4_pow", 64'(peak_pow), 64'(33'h0_8000_0000));
    chk("t4_ovf", 64'(overflow), 64'(1'b0));
    drain();

    // two commits with no consumer
    zero_frame();
    fr_cen[100] = 32'h0005_0000;
    send_frame();
    at_commit();
    chk("t5_first_valid", 64'(out_valid), 64'(1'b1));
    zero_frame();
    fr_cen[300] = 32'h0000_0007;
    send_frame();
    tick();
    chk("t5_ovf_early", 64'(overflow), 64'(1'b0));
    tick();
    chk("t5_ovf_pulse", 64'(overflow), 64'(1'b1));
    chk("t5_held_bin", 64'(peak_bin), 64'(100));
    chk("t5_held_pow", 64'(peak_pow), 64'(25));
    tick();
    chk("t5_ovf_single", 64'(overflow), 64'(1'b0));
    chk("t5_still_valid", 64'(out_valid), 64'(1'b1));
    drain();

    // commit in the same cycle the held snapshot is accepted
    zero_frame();
    fr_cen[50] = 32'h0003_0000;
    send_frame();
    at_commit();
    chk("t7_first_bin", 64'(peak_bin), 64'(50));
    zero_frame();
    fr_cen[60] = 32'h0004_0000;
    send_frame();
    tick();
    out_ready = 1;
    tick();
    chk("t7_valid", 64'(out_valid), 64'(1'b1));
    chk("t7_ovf", 64'(overflow), 64'(1'b0));
    chk("t7_bin", 64'(peak_bin), 64'(60));
    chk("t7_pow", 64'(peak_pow), 64'(16));
    tick();
    chk("t7_drained", 64'(out_valid), 64'(1'b0));
    out_ready = 0;

    // early tlast, then an all-zero frame, then a normal frame
    zero_frame();
    fr_cen[50] = 32'h0009_0000;
    send_range(0, 100, 100);
    tick();
    chk("t6_ferr_early", 64'(frame_error), 64'(1'b0));
    tick();
    chk("t6_ferr_pulse", 64'(frame_error), 64'(1'b1));
    chk("t6_no_valid", 64'(out_valid), 64'(1'b0));
    zero_frame();
    send_frame();
    at_commit();
    chk("t6_zero_no_valid", 64'(out_valid), 64'(1'b0));
    chk("t6_zero_no_ferr", 64'(frame_error), 64'(1'b0));
    fr_cen[77] = 32'h0012_0034;
    fr_per[77] = {32'h1, 32'h2, 32'h3};
    send_frame();
    at_commit();
    chk("t6_bin", 64'(peak_bin), 64'(77));
    chk("t6_pow", 64'(peak_pow), 64'(3028));
    chk("t6_central", 64'(central_mic), 64'(32'h0012_0034));
    chk("t6_periph0", 64'(peripheral_mics[0]), 64'(32'h3));
    chk("t6_periph2", 64'(peripheral_mics[2]), 64'(32'h1));
    drain();

    // randomized frames against the model
    rdy_rand = 1;
    gap_pct  = 5;
    for (int f = 0; f < 8; f++) begin
      zero_frame();
      for (int i = 0; i < N; i++) begin
        case (f % 3)
          0: begin
            vre = 16'($urandom_range(0, 6)) - 16'd3;
            vim = 16'($urandom_range(0, 6)) - 16'd3;
            fr_cen[i] = {vre, vim};
          end
          1: fr_cen[i] = $urandom;
          default: if ($urandom_range(0, 199) == 0) fr_cen[i] = {16'($urandom_range(0, 8)), 16'h0};
        endcase
        fr_per[i] = {$urandom, $urandom, $urandom};
      end
      if (f == 4) begin
        len = $urandom_range(1, 900);
        send_range(0, len, len);
      end else if (f == 5) begin
        send_range(0, N - 1, -1);
      end else begin
        send_frame();
      end
    end
    gap_pct  = 0;
    rdy_rand = 0;
    out_ready = 1;
    repeat (10) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
